// File: rtl/prg_inject_loader_pkg.sv
// Shared types and constants for the PRG/cartridge inject loader.
// Holds the FSM state enum, the VIC-20 pointer list and the FIFO entry layout.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DRAIN  = 2'd2,
      INJECT = 2'd3
   } state_t;

   localparam int unsigned LOADER_ADDR_W = 16;

   // Entry 0 sits in the LSBs: 002D, 002F, 0031, 00AE.
   localparam logic [4*LOADER_ADDR_W-1:0] VIC20_PTRS =
      {16'h00AE, 16'h0031, 16'h002F, 16'h002D};

   typedef struct packed {
      logic [LOADER_ADDR_W-1:0] addr;
      logic [7:0]               data;
   } fifo_entry_t;

endpackage

// File: rtl/prg_inject_loader_if.sv
// Memory write port of the inject loader: request/acknowledge with address and data.
// A write is taken on any clock edge where mem_req and mem_ack are both high;
// mem_addr/mem_data/mem_req stay stable while mem_req is high and mem_ack is low.
interface prg_inject_loader_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              mem_req;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   modport master (output mem_req, output mem_addr, output mem_data, input mem_ack);
   modport slave  (input mem_req, input mem_addr, input mem_data, output mem_ack);
endinterface

// File: rtl/prg_inject_loader_fifo.sv
// Synchronous FIFO with a registered head entry; the head register counts
// toward DEPTH so total occupancy never exceeds DEPTH entries.
module loader_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt, occ;
   logic             pop_ok, push_ok, st_rd, full;

   assign occ        = cnt + {{AW{1'b0}}, head_valid};
   assign full       = (occ == (AW+1)'(DEPTH));
   assign pop_ok     = pop && head_valid;
   // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
   assign push_ready = !full || pop_ok;
   assign push_ok    = push && push_ready;
   assign st_rd      = (cnt != '0) && (!head_valid || pop_ok);
   assign empty      = (cnt == '0) && !head_valid;

   always_ff @(posedge clk_sys) begin
      if (push_ok) store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (st_rd) begin
            head_data  <= store[rd_ptr];
            head_valid <= 1'b1;
            rd_ptr     <= rd_ptr + 1'b1;
         end else if (pop_ok) begin
            head_valid <= 1'b0;
         end
         cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, st_rd};
      end
   end

endmodule

// File: rtl/prg_inject_loader.sv
// PRG/cartridge loader: streams data_io bytes into memory through a FIFO, then
// writes the end address into NUM_PTRS zero-page pointers. PRG_LOADER_AUTORESET_EN enables reset_req.
module prg_inject_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RAW_BASE = ADDR_W'(16'hA000),
   parameter int unsigned NUM_PTRS   = 4,
   parameter logic [NUM_PTRS*ADDR_W-1:0] PTR_ADDRS = VIC20_PTRS
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   input  logic              use_header,
   prg_inject_loader_if.master mem,
   output logic              busy,
   output logic [ADDR_W-1:0] end_addr,
   output logic              overflow,
   output logic              reset_req,
   output state_t            dbg_state
);
   localparam int unsigned IDX_W = $clog2(2*NUM_PTRS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*NUM_PTRS-1);

   state_t            state;
   logic              dl_active_q;
   logic [ADDR_W-1:0] wptr;
   logic              inj_req;
   logic [ADDR_W-1:0] inj_addr;
   logic [7:0]        inj_data;
   logic [IDX_W-1:0]  inj_idx;
   fifo_entry_t       push_entry, head_entry;
   logic              push, push_ready, head_valid, fifo_pop, fifo_empty;
   logic              hdr_byte, load_start, inject_done;

   // Pointer k/2 gets its low byte at even k and its high byte at odd k.
   function automatic logic [ADDR_W-1:0] ptr_target(input logic [IDX_W-1:0] k);
      return PTR_ADDRS[(int'(k) / 2) * ADDR_W +: ADDR_W] + ADDR_W'(k[0]);
   endfunction

   function automatic logic [7:0] ptr_byte(input logic [IDX_W-1:0] k, input logic [ADDR_W-1:0] e);
      return k[0] ? e[15:8] : e[7:0];
   endfunction

   assign hdr_byte    = use_header && (dl_addr < ADDR_W'(2));
   assign push        = (state == LOAD) && dl_wr && !hdr_byte;
   assign push_entry  = '{addr: LOADER_ADDR_W'(wptr), data: dl_data};
   assign fifo_pop    = mem.mem_ack && (state != INJECT);
   assign load_start  = (state == IDLE) && dl_active && !dl_active_q;
   assign inject_done = (state == INJECT) && mem.mem_ack && (inj_idx == LAST_IDX);

   loader_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .push       (push),
      .push_data  (push_entry),
      .push_ready (push_ready),
      .pop        (fifo_pop),
      .head_valid (head_valid),
      .head_data  (head_entry),
      .empty      (fifo_empty)
   );

   assign mem.mem_req  = (state == INJECT) ? inj_req  : head_valid;
   assign mem.mem_addr = (state == INJECT) ? inj_addr : ADDR_W'(head_entry.addr);
   assign mem.mem_data = (state == INJECT) ? inj_data : head_entry.data;
   assign end_addr     = wptr;
   assign dbg_state    = state;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         dl_active_q <= 1'b0;
         wptr        <= '0;
         overflow    <= 1'b0;
         inj_req     <= 1'b0;
         inj_addr    <= '0;
         inj_data    <= '0;
         inj_idx     <= '0;
      end else begin
         dl_active_q <= dl_active;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  overflow <= 1'b0;
                  wptr     <= RAW_BASE;
                  inj_idx  <= '0;
               end
            end
            LOAD: begin
               if (dl_wr) begin
                  if (hdr_byte) begin
                     if (dl_addr[0]) wptr[15:8] <= dl_data;
                     else            wptr[7:0]  <= dl_data;
                  end else begin
                     // Address advances even for a dropped byte so later data lands correctly.
                     wptr <= wptr + 1'b1;
                     if (!push_ready) overflow <= 1'b1;
                  end
               end
               if (!dl_active) state <= DRAIN;
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state    <= INJECT;
                  inj_req  <= 1'b1;
                  inj_idx  <= '0;
                  inj_addr <= ptr_target('0);
                  inj_data <= ptr_byte('0, wptr);
               end
            end
            INJECT: begin
               if (inject_done) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  inj_req <= 1'b0;
               end else if (mem.mem_ack) begin
                  inj_idx  <= inj_idx + 1'b1;
                  inj_addr <= ptr_target(inj_idx + 1'b1);
                  inj_data <= ptr_byte(inj_idx + 1'b1, wptr);
               end
            end
            default: state <= IDLE;
         endcase
         if (dl_wr && ((state == DRAIN) || (state == INJECT))) overflow <= 1'b1;
      end
   end

`ifdef PRG_LOADER_AUTORESET_EN
   logic hit, reset_pulse;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hit         <= 1'b0;
         reset_pulse <= 1'b0;
      end else begin
         reset_pulse <= 1'b0;
         if (load_start) begin
            hit <= 1'b0;
         end else if (push && push_ready && (wptr == RAW_BASE)) begin
            hit <= 1'b1;
         end else if (inject_done) begin
            reset_pulse <= hit;
            hit         <= 1'b0;
         end
      end
   end

   assign reset_req = reset_pulse;
`else
   assign reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_prg_inject_loader.sv
// Directed bench for prg_inject_loader: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares every accepted memory write.
module tb_prg_inject_loader;
   import loader_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        dl_active, dl_wr, use_header;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic        busy, overflow, reset_req;
   logic [15:0] end_addr;
   state_t      dbg_state;
   logic        ack_en;

   always #5 clk_sys = ~clk_sys;

   prg_inject_loader_if #(.ADDR_W(16)) mif ();
   assign mif.mem_ack = ack_en;

   prg_inject_loader dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .dl_active  (dl_active),
      .dl_wr      (dl_wr),
      .dl_addr    (dl_addr),
      .dl_data    (dl_data),
      .use_header (use_header),
      .mem        (mif),
      .busy       (busy),
      .end_addr   (end_addr),
      .overflow   (overflow),
      .reset_req  (reset_req),
      .dbg_state  (dbg_state)
   );

`ifdef PRG_LOADER_AUTORESET_EN
   localparam int RAW_PULSES = 1;
`else
   localparam int RAW_PULSES = 0;
`endif

   localparam logic [15:0] PTRS [4] = '{16'h002D, 16'h002F, 16'h0031, 16'h00AE};

   int          tests_run = 0;
   int          fails = 0;
   int          wr_count = 0;
   int          rr_count = 0;
   logic [23:0] exp_q[$];
   logic        stall_pend = 1'b0;
   logic [23:0] stall_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted write is checked against the head of exp_q.
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check("hold_req", mif.mem_req, 1'b1);
            if (mif.mem_req) check("hold_addr_data", {mif.mem_addr, mif.mem_data}, stall_val);
         end
         stall_pend = 1'b0;
         if (mif.mem_req && mif.mem_ack) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               fails++;
               $display("FAIL unexpected_write: got %0h expected no write", {mif.mem_addr, mif.mem_data});
            end else begin
               check("write", {mif.mem_addr, mif.mem_data}, exp_q.pop_front());
            end
            wr_count++;
         end else if (mif.mem_req) begin
            stall_pend = 1'b1;
            stall_val  = {mif.mem_addr, mif.mem_data};
         end
         if (reset_req) rr_count++;
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_load(input logic hdr);
      use_header = hdr;
      dl_active  = 1'b1;
      tick();
      check("busy_rise", busy, 1'b1);
   endtask

   task automatic send(input logic [15:0] off, input logic [7:0] d);
      dl_addr = off;
      dl_data = d;
      dl_wr   = 1'b1;
      tick();
      dl_wr   = 1'b0;
   endtask

   task automatic end_load();
      dl_active = 1'b0;
      tick();
   endtask

   task automatic expw(input logic [15:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic exp_inject(input logic [15:0] e);
      for (int i = 0; i < 4; i++) begin
         expw(PTRS[i], e[7:0]);
         expw(PTRS[i] + 16'd1, e[15:8]);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check({name, "_idle"}, busy, 1'b0);
      check({name, "_queue_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_writes(input int target, input string name);
      int n = 0;
      while (wr_count < target && n < 300) begin
         tick();
         n++;
      end
      check(name, (wr_count >= target), 1'b1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_mem_req"}, mif.mem_req, 1'b0);
      check({name, "_mem_addr"}, mif.mem_addr, 16'h0);
      check({name, "_mem_data"}, mif.mem_data, 8'h0);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_end_addr"}, end_addr, 16'h0);
      check({name, "_overflow"}, overflow, 1'b0);
      check({name, "_reset_req"}, reset_req, 1'b0);
   endtask

   initial begin
      int rr0, wr0;
      reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; use_header = 1'b0;
      dl_addr = '0; dl_data = '0; ack_en = 1'b1;
      tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Header load 1001: AA BB CC
      rr0 = rr_count;
      start_load(1'b1);
      send(16'd0, 8'h01);
      send(16'd1, 8'h10);
      expw(16'h1001, 8'hAA); send(16'd2, 8'hAA);
      check("push_latency_req_low", mif.mem_req, 1'b0);
      expw(16'h1002, 8'hBB); send(16'd3, 8'hBB);
      check("req_after_push", mif.mem_req, 1'b1);
      expw(16'h1003, 8'hCC); send(16'd4, 8'hCC);
      end_load();
      check("hdr_end_addr", end_addr, 16'h1004);
      exp_inject(16'h1004);
      wait_idle("hdr");
      check("hdr_overflow", overflow, 1'b0);
      tick(); tick();
      check("hdr_no_reset_req", rr_count - rr0, 0);

      // Raw load at RAW_BASE
      rr0 = rr_count;
      start_load(1'b0);
      expw(16'hA000, 8'h11); send(16'd0, 8'h11);
      expw(16'hA001, 8'h22); send(16'd1, 8'h22);
      expw(16'hA002, 8'h33); send(16'd2, 8'h33);
      end_load();
      check("raw_end_addr", end_addr, 16'hA003);
      exp_inject(16'hA003);
      wait_idle("raw");
      tick(); tick(); tick();
      check("raw_reset_pulses", rr_count - rr0, RAW_PULSES);
      check("raw_reset_req_low", reset_req, 1'b0);

      // Backpressure: ack low for 20 cycles during a 6-byte load
      ack_en = 1'b0;
      start_load(1'b1);
      send(16'd0, 8'h00);
      send(16'd1, 8'h20);
      for (int i = 0; i < 6; i++) begin
         expw(16'h2000 + 16'(i), 8'hB0 + 8'(i));
         send(16'(2 + i), 8'hB0 + 8'(i));
      end
      repeat (11) tick();
      check("bp_head_addr", mif.mem_addr, 16'h2000);
      check("bp_head_data", mif.mem_data, 8'hB0);
      ack_en = 1'b1;
      end_load();
      check("bp_end_addr", end_addr, 16'h2006);
      exp_inject(16'h2006);
      wait_idle("bp");
      check("bp_overflow", overflow, 1'b0);

      // Overflow: 12 bytes with ack held low, only 8 fit
      wr0 = wr_count;
      ack_en = 1'b0;
      start_load(1'b1);
      send(16'd0, 8'h00);
      send(16'd1, 8'h30);
      for (int i = 0; i < 12; i++) begin
         if (i < 8) expw(16'h3000 + 16'(i), 8'h40 + 8'(i));
         send(16'(2 + i), 8'h40 + 8'(i));
      end
      end_load();
      check("ovf_flag", overflow, 1'b1);
      check("ovf_end_addr", end_addr, 16'h300C);
      check("ovf_no_write_while_stalled", wr_count - wr0, 0);
      exp_inject(16'h300C);
      ack_en = 1'b1;
      wait_idle("ovf");
      check("ovf_write_count", wr_count - wr0, 16);
      check("ovf_sticky", overflow, 1'b1);

      // Wrap at the top of memory; new load clears overflow
      start_load(1'b1);
      check("wrap_overflow_cleared", overflow, 1'b0);
      send(16'd0, 8'hFE);
      send(16'd1, 8'hFF);
      expw(16'hFFFE, 8'hD1); send(16'd2, 8'hD1);
      expw(16'hFFFF, 8'hD2); send(16'd3, 8'hD2);
      expw(16'h0000, 8'hD3); send(16'd4, 8'hD3);
      expw(16'h0001, 8'hD4); send(16'd5, 8'hD4);
      end_load();
      check("wrap_end_addr", end_addr, 16'h0002);
      exp_inject(16'h0002);
      wait_idle("wrap");

      // Full FIFO: push and pop in the same cycle is accepted
      ack_en = 1'b0;
      start_load(1'b1);
      send(16'd0, 8'h00);
      send(16'd1, 8'h40);
      for (int i = 0; i < 8; i++) begin
         expw(16'h4000 + 16'(i), 8'hC0 + 8'(i));
         send(16'(2 + i), 8'hC0 + 8'(i));
      end
      ack_en = 1'b1;
      expw(16'h4008, 8'hC8); send(16'd10, 8'hC8);
      end_load();
      check("full_pushpop_overflow", overflow, 1'b0);
      check("full_pushpop_end_addr", end_addr, 16'h4009);
      exp_inject(16'h4009);
      wait_idle("full_pushpop");

      // Reset after the third pointer write
      wr0 = wr_count;
      start_load(1'b1);
      send(16'd0, 8'h00);
      send(16'd1, 8'h50);
      expw(16'h5000, 8'hE1); send(16'd2, 8'hE1);
      expw(16'h5001, 8'hE2); send(16'd3, 8'hE2);
      end_load();
      exp_inject(16'h5002);
      wait_writes(wr0 + 5, "mid_inject_reach");
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_inject_reset");
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
      start_load(1'b1);
      send(16'd0, 8'h00);
      send(16'd1, 8'h60);
      expw(16'h6000, 8'h77); send(16'd2, 8'h77);
      end_load();
      check("post_reset_end_addr", end_addr, 16'h6001);
      exp_inject(16'h6001);
      wait_idle("post_reset");

      // dl_wr and a dl_active rise during INJECT
      start_load(1'b1);
      send(16'd0, 8'h00);
      send(16'd1, 8'h70);
      expw(16'h7000, 8'h88); send(16'd2, 8'h88);
      end_load();
      exp_inject(16'h7001);
      begin
         int n = 0;
         while (dbg_state != INJECT && n < 100) begin
            tick();
            n++;
         end
      end
      check("reach_inject", dbg_state, INJECT);
      dl_active = 1'b1;
      send(16'd5, 8'h99);
      check("inj_dlwr_overflow", overflow, 1'b1);
      check("inj_dlwr_end_addr", end_addr, 16'h7001);
      wait_idle("inj_dlwr");
      repeat (3) tick();
      check("no_load_from_inject_rise", busy, 1'b0);
      dl_active = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
